// File: rtl/ifu_fetch_buf.sv
// Instruction fetch buffer: issues in-order ibus reads at pc_i, queues returned words for decode.
// Optional same-cycle response bypass to decode when IFU_FETCH_BUF_BYPASS_EN is defined.
module ifu_fetch_buf #(
    parameter int DEPTH = 2,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_i,
    input  logic          flush_i,
    input  logic          hold_i,
    output logic          pc_stall_o,
    output logic          ibus_req_o,
    output logic [AW-1:0] ibus_addr_o,
    input  logic          ibus_gnt_i,
    input  logic          ibus_rvalid_i,
    input  logic [DW-1:0] ibus_rdata_i,
    output logic          inst_valid_o,
    input  logic          inst_ready_i,
    output logic [DW-1:0] inst_o,
    output logic [AW-1:0] inst_addr_o
);

    localparam int PW  = $clog2(DEPTH);
    // Back-to-back flushes can stack several windows of in-flight responses.
    localparam int DCW = PW + 4;

    localparam logic [PW:0]    CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]    ONE_X    = (PW+1)'(1);
    localparam logic [PW-1:0]  ONE_P    = PW'(1);
    localparam logic [DCW-1:0] ONE_D    = DCW'(1);
    localparam logic [DW-1:0]  NOP      = DW'(32'h0000_0013);

    logic [AW-1:0]    ent_addr [DEPTH];
    logic [DW-1:0]    ent_data [DEPTH];
    logic [DEPTH-1:0] ent_filled;

    // Write and fill pointers carry a wrap bit so their difference gives the outstanding count.
    logic [PW:0]      wr_x, fill_x, count, pend;
    logic [PW-1:0]    rd_ptr, wr_idx, fill_idx;
    logic [DCW-1:0]   discard, disc_total;
    logic             alloc, fill_ok, pop, bypass;

    assign wr_idx   = wr_x[PW-1:0];
    assign fill_idx = fill_x[PW-1:0];
    assign pend     = wr_x - fill_x;

    always_comb begin
        ibus_req_o  = !rst && !flush_i && !hold_i && (count < CNT_FULL);
        alloc       = ibus_req_o && ibus_gnt_i;
        pc_stall_o  = !alloc;
        ibus_addr_o = pc_i;
        fill_ok     = ibus_rvalid_i && (discard == '0) && !flush_i && (pend != '0);
        disc_total  = discard + DCW'(pend);
    end

`ifdef IFU_FETCH_BUF_BYPASS_EN
    assign bypass = fill_ok && (fill_idx == rd_ptr);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        inst_valid_o = ent_filled[rd_ptr] || bypass;
        inst_o       = NOP;
        inst_addr_o  = '0;
        if (bypass) begin
            inst_o = ibus_rdata_i;
        end else if (ent_filled[rd_ptr]) begin
            inst_o = ent_data[rd_ptr];
        end
        if (inst_valid_o) begin
            inst_addr_o = ent_addr[rd_ptr];
        end
        pop = inst_valid_o && inst_ready_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_x       <= '0;
            fill_x     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            discard    <= '0;
            ent_filled <= '0;
        end else if (flush_i) begin
            fill_x     <= wr_x;
            rd_ptr     <= wr_idx;
            count      <= '0;
            ent_filled <= '0;
            // A response arriving on the flush edge is the oldest one in flight and is dropped here.
            discard    <= (ibus_rvalid_i && (disc_total != '0)) ? disc_total - ONE_D : disc_total;
        end else begin
            if (alloc) begin
                wr_x               <= wr_x + ONE_X;
                ent_filled[wr_idx] <= 1'b0;
            end
            if (ibus_rvalid_i && (discard != '0)) begin
                discard <= discard - ONE_D;
            end
            if (fill_ok) begin
                fill_x <= fill_x + ONE_X;
                if (!(bypass && inst_ready_i)) begin
                    ent_filled[fill_idx] <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr             <= rd_ptr + ONE_P;
                ent_filled[rd_ptr] <= 1'b0;
            end
            if (alloc && !pop) begin
                count <= count + ONE_X;
            end else if (pop && !alloc) begin
                count <= count - ONE_X;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            ent_addr[wr_idx] <= pc_i;
        end
        if (fill_ok) begin
            ent_data[fill_idx] <= ibus_rdata_i;
        end
    end

endmodule

// File: tb/tb_ifu_fetch_buf.sv
// Scoreboard bench for ifu_fetch_buf: random bus/decode/flush stimulus against a queue-level model.
module tb_ifu_fetch_buf;

    localparam int          DEPTH = 2;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IFU_FETCH_BUF_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst, flush_i, hold_i, ibus_gnt_i, ibus_rvalid_i, inst_ready_i;
    logic [31:0] pc_i, ibus_rdata_i;
    logic        pc_stall_o, ibus_req_o, inst_valid_o;
    logic [31:0] ibus_addr_o, inst_o, inst_addr_o;

    always #5 clk = ~clk;

    ifu_fetch_buf #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .flush_i      (flush_i),
        .hold_i       (hold_i),
        .pc_stall_o   (pc_stall_o),
        .ibus_req_o   (ibus_req_o),
        .ibus_addr_o  (ibus_addr_o),
        .ibus_gnt_i   (ibus_gnt_i),
        .ibus_rvalid_i(ibus_rvalid_i),
        .ibus_rdata_i (ibus_rdata_i),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } bus_t;

    bus_t        bus_q[$];   // granted reads still owed by the bus, oldest first
    logic [31:0] exp_q[$];   // fetches decode should still receive, oldest first

    int          n_chk = 0, n_pass = 0, cyc = 0;
    int          p_gnt, p_rdy, p_flush, p_hold, lat_min, lat_max;
    logic [31:0] jump_pc, pc_m, prev_addr, mon_e, first_pop_addr;
    logic        rst_knob, prev_alloc, prev_flush, prev_rst, req_e, grab;
    int          first_gnt, first_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic roll(input int p);
        return int'($urandom_range(99, 0)) < p;
    endfunction

    task automatic cycle();
        bus_t b;
        @(posedge clk);
        cyc++;
        if (prev_rst) begin
            exp_q.delete();
            bus_q.delete();
        end else if (prev_flush) begin
            exp_q.delete();
            pc_m = (jump_pc != 0) ? jump_pc : 32'h1000 + 32'(4 * $urandom_range(1023, 0));
        end else if (prev_alloc) begin
            exp_q.push_back(prev_addr);
            b.addr = prev_addr;
            b.due  = cyc - 1 + int'($urandom_range(lat_max, lat_min));
            bus_q.push_back(b);
            pc_m = pc_m + 32'd4;
        end
        #1;
        rst           = rst_knob;
        flush_i       = !rst_knob && roll(p_flush);
        hold_i        = roll(p_hold);
        ibus_gnt_i    = roll(p_gnt);
        inst_ready_i  = !rst_knob && roll(p_rdy);
        pc_i          = pc_m;
        ibus_rvalid_i = 1'b0;
        ibus_rdata_i  = $urandom;
        if (rst_knob) begin
            bus_q.delete();
        end else if (bus_q.size() > 0 && bus_q[0].due <= cyc) begin
            ibus_rvalid_i = 1'b1;
            ibus_rdata_i  = bus_q[0].addr ^ KEY;
            void'(bus_q.pop_front());
        end
        #2;
        req_e = !rst && !flush_i && !hold_i && (exp_q.size() < DEPTH);
        chk("ibus_req", 32'(ibus_req_o), 32'(req_e));
        chk("pc_stall", 32'(pc_stall_o), 32'(!(req_e && ibus_gnt_i)));
        chk("ibus_addr", ibus_addr_o, pc_m);
        prev_alloc = req_e && ibus_gnt_i;
        prev_addr  = pc_m;
        prev_flush = flush_i;
        prev_rst   = rst;
        if (prev_alloc && first_gnt < 0) first_gnt = cyc;
    endtask

    task automatic do_reset(input logic [31:0] pc0);
        rst_knob = 1'b1;
        cycle();
        cycle();
        chk("rst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_inst", inst_o, NOP);
        chk("rst_addr", inst_addr_o, 32'd0);
        chk("rst_req", 32'(ibus_req_o), 32'd0);
        chk("rst_stall", 32'(pc_stall_o), 32'd1);
        rst_knob = 1'b0;
        pc_m     = pc0;
    endtask

    task automatic knobs(input int g, input int r, input int f, input int h,
                         input int lmin, input int lmax, input logic [31:0] jp);
        p_gnt = g; p_rdy = r; p_flush = f; p_hold = h;
        lat_min = lmin; lat_max = lmax; jump_pc = jp;
    endtask

    // Monitor: every delivered instruction must be the oldest expected fetch.
    always @(negedge clk) begin
        if (!rst) begin
            if (inst_valid_o) begin
                if (first_val < 0) first_val = cyc;
                if (inst_ready_i) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_inst: got addr %h data %h, expected none", inst_addr_o, inst_o);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (grab) begin
                            first_pop_addr = inst_addr_o;
                            grab = 1'b0;
                        end
                        chk("inst_addr", inst_addr_o, mon_e);
                        chk("inst_data", inst_o, mon_e ^ KEY);
                    end
                end
            end else begin
                chk("idle_inst", inst_o, NOP);
                chk("idle_addr", inst_addr_o, 32'd0);
            end
        end
    end

    initial begin
        rst = 1'b1; flush_i = 1'b0; hold_i = 1'b0; ibus_gnt_i = 1'b0;
        ibus_rvalid_i = 1'b0; inst_ready_i = 1'b0; pc_i = '0; ibus_rdata_i = '0;
        prev_alloc = 1'b0; prev_flush = 1'b0; prev_rst = 1'b0; prev_addr = '0;
        pc_m = '0; grab = 1'b0; first_pop_addr = '0; mon_e = '0; req_e = 1'b0;
        first_gnt = -1; first_val = -1;
        knobs(100, 100, 0, 0, 1, 1, 32'h0);
        do_reset(32'h0);

        // Streaming from PC 0 with one-cycle bus latency
        first_gnt = -1; first_val = -1;
        repeat (12) cycle();
        chk("first_latency", 32'(first_val - first_gnt), 32'(LAT));

        // Decode stalls until the queue is full, then releases one entry
        p_rdy = 0;
        repeat (5) cycle();
        chk("full_req", 32'(ibus_req_o), 32'd0);
        chk("full_stall", 32'(pc_stall_o), 32'd1);
        p_rdy = 100;
        cycle();
        chk("full_pop_req", 32'(ibus_req_o), 32'd0);
        cycle();
        chk("req_reasserts", 32'(ibus_req_o), 32'd1);

        // Flush with two fetches outstanding
        do_reset(32'h10);
        knobs(100, 100, 0, 0, 3, 3, 32'h100);
        cycle(); cycle();
        p_flush = 100; cycle(); p_flush = 0;
        grab = 1'b1;
        repeat (10) cycle();
        chk("flush_first_addr", first_pop_addr, 32'h100);

        // Flush coinciding with the first response
        do_reset(32'h10);
        knobs(100, 100, 0, 0, 2, 2, 32'h100);
        cycle(); cycle();
        p_flush = 100; cycle(); p_flush = 0;
        grab = 1'b1;
        repeat (10) cycle();
        chk("flush_rv_first_addr", first_pop_addr, 32'h100);

        // Hold with one fetch outstanding
        do_reset(32'h200);
        knobs(100, 100, 0, 0, 2, 2, 32'h0);
        cycle();
        p_hold = 100;
        repeat (3) begin
            cycle();
            chk("hold_stall", 32'(pc_stall_o), 32'd1);
        end
        cycle();
        chk("hold_delivered", 32'(exp_q.size()), 32'd0);

        // Random traffic
        do_reset(32'h0);
        knobs(70, 60, 5, 10, 1, 3, 32'h0);
        repeat (3000) cycle();

        // Fill the queue, then reset mid-stream
        knobs(100, 0, 0, 0, 1, 3, 32'h0);
        repeat (8) cycle();
        chk("pre_reset_full", 32'(exp_q.size()), 32'(DEPTH));
        do_reset(32'h40);

        // Short stream after reset, then drain with fetching held off
        knobs(80, 100, 0, 0, 1, 3, 32'h0);
        repeat (20) cycle();
        p_hold = 100;
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) cycle();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
